muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RV32M/RV64M execution unit for the integer datapath, sitting beside the single-cycle ALU.
- Takes the multiply/divide ALUControl codes and adds the high-half multiplies.
- Multiplies complete in 1 cycle. Divides and remainders use a radix-2 restoring divider, with a fast path for divide-by-zero and signed overflow.
- Valid/ready handshakes on both sides, plus a flush input for pipeline kills.

Parameters:
- XLEN, 32, operand and result width in bits (32 or 64).
- CNT_W, $clog2(XLEN)+1, width of the iteration counter (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request.
- A  input  XLEN  operand rs1.
- B  input  XLEN  operand rs2.
- ALUControl  input  4  op code: 1000 MUL, 1001 MULH, 1110 MULHSU, 1111 MULHU, 1010 DIV, 1011 DIVU, 1100 REM, 1101 REMU.
- flush  input  1  abort any in-flight operation.
- out_valid  output  1  Result valid.
- out_ready  input  1  consumer takes Result.
- Result  output  XLEN  registered result.
- zero  output  1  Result == 0, registered with Result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; out_valid=0; Result=0; zero=1; counter=0.
  - in_ready=1 once rst_n deasserts.
- States: IDLE, MUL, DIV, FIX, DONE.
- in_ready=1 only in IDLE. Accept on the edge where in_valid & in_ready. A, B and op are latched at accept.
- From IDLE at accept:
  - Multiply op → MUL.
  - Divide op with B==0 or signed overflow (DIV/REM, A=most-negative, B=all-ones) → FIX (fast path).
  - Other divide op → DIV, counter=0.
  - Unrecognised op → FIX with Result forced to 0.
- MUL (1 edge): full 2*XLEN product, signedness per op.
  - MUL → low XLEN bits.
  - MULH (s×s), MULHSU (s×u), MULHU (u×u) → high XLEN bits.
  - Next state DONE.
- DIV:
  - Operand magnitudes are taken at accept (signed ops use abs(); unsigned ops pass through).
  - One quotient bit per edge, MSB first: shift remainder left, subtract divisor, keep or restore.
  - Counter increments each edge. After XLEN iterations → FIX.
- FIX (1 edge): sign correction and final select, then → DONE.
  - Quotient negated iff signed op and sign(A)≠sign(B).
  - Remainder takes sign(A).
  - B==0: DIV/DIVU → all ones; REM/REMU → A.
  - Overflow: DIV → A (most-negative); REM → 0.
- Latency, counted as edges after the accept edge to out_valid=1:
  - MUL: 1.
  - Fast path / bad op: 1.
  - Normal divide: XLEN+1 (33 at XLEN=32).
- DONE:
  - out_valid=1. Result and zero are stable and held while out_ready=0 (backpressure, any duration).
  - On out_valid & out_ready → IDLE, out_valid=0.
  - A new accept is possible on the following edge; there is no accept in the same edge as the out handshake.
- flush (synchronous, highest priority after reset):
  - From any state → IDLE next edge, out_valid=0; the in-flight result is discarded.
  - flush in IDLE with in_valid=1 → no accept.
- Reset mid-divide: immediate return to reset values; partial state discarded.
- Result and zero change only on entry to DONE or on reset. No combinational path from inputs to outputs except in_ready (which depends on state only).

Test Plan:
- XLEN=32:
  - MULH A=0x80000000, B=0x80000000 → Result=0x40000000 1 cycle after accept.
  - MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF → Result=0xFFFFFFFF.
  - MULHU same operands → 0xFFFFFFFE.
  - MUL → 0x00000001.
- DIV A=-7 (0xFFFFFFF9), B=2 → Result=0xFFFFFFFD after exactly 33 edges. REM on same operands → 0xFFFFFFFF. DIVU A=100, B=7 → 14; REMU → 2, zero=0.
- DIV A=5, B=0 → 0xFFFFFFFF after 1 edge. REMU A=5, B=0 → 5. DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000. REM on same operands → 0, zero=1.
- Backpressure: out_ready low 10 cycles in DONE → out_valid, Result and zero held constant, in_ready=0. out_ready high → IDLE next edge, next request accepted the edge after.
- flush asserted at iteration 12 of DIVU → IDLE next edge, out_valid never rises. A following MUL 3×4 returns 12 correctly.
- rst_n pulled low at iteration 20 of DIV → outputs immediately Result=0, zero=1, out_valid=0. Random regression at XLEN=32 and 64 against a reference model for all 8 ops, including zero and extreme operands.

Source files
------------

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: single-cycle multiply, radix-2 restoring divide.
// state | meaning: IDLE accept | MUL form product | DIV one quotient bit/edge | FIX sign/select | DONE hold result
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      ALUControl,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            zero
);

  localparam logic [3:0] OP_MUL    = 4'b1000;
  localparam logic [3:0] OP_MULH   = 4'b1001;
  localparam logic [3:0] OP_MULHSU = 4'b1110;
  localparam logic [3:0] OP_MULHU  = 4'b1111;
  localparam logic [3:0] OP_DIV    = 4'b1010;
  localparam logic [3:0] OP_DIVU   = 4'b1011;
  localparam logic [3:0] OP_REM    = 4'b1100;
  localparam logic [3:0] OP_REMU   = 4'b1101;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t state, nxt;

  logic [XLEN-1:0]  a_q, b_q, quo_q, dvs_q, rem_q;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic             bz_q, ovf_q, bad_q;

  logic accept, in_mul, in_div, in_sdiv, in_bz, in_ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid & in_ready & ~flush;

  assign in_mul  = ALUControl inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  assign in_div  = ALUControl inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign in_sdiv = (ALUControl == OP_DIV) || (ALUControl == OP_REM);
  assign in_bz   = (B == '0);
  assign in_ovf  = in_sdiv && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
  assign a_mag   = (in_sdiv && A[XLEN-1]) ? -A : A;
  assign b_mag   = (in_sdiv && B[XLEN-1]) ? -B : B;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (accept) begin
        if (in_mul)                     nxt = S_MUL;
        else if (in_div && !in_bz && !in_ovf) nxt = S_DIV;
        else                            nxt = S_FIX;
      end
      S_MUL:  nxt = S_DONE;
      S_DIV:  if (cnt == CNT_W'(XLEN - 1)) nxt = S_FIX;
      S_FIX:  nxt = S_DONE;
      S_DONE: if (out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (flush) nxt = S_IDLE;
  end

  // Restoring step: the difference fits XLEN bits whenever it is kept.
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_diff, rem_nx, quo_nx;
  logic            ge;

  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign ge       = rem_sh >= {1'b0, dvs_q};
  assign rem_diff = rem_sh[XLEN-1:0] - dvs_q;
  assign rem_nx   = ge ? rem_diff : rem_sh[XLEN-1:0];
  assign quo_nx   = {quo_q[XLEN-2:0], ge};

  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0]   mul_res;
  logic              a_sgn, b_sgn;

  assign a_sgn   = (op_q == OP_MULH) || (op_q == OP_MULHSU);
  assign b_sgn   = (op_q == OP_MULH);
  assign mul_a   = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q};
  assign mul_b   = {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
  assign prod    = mul_a * mul_b;
  assign mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  logic            is_rem, is_sdiv;
  logic [XLEN-1:0] q_fix, r_fix, fix_res, res_nx;

  assign is_rem  = (op_q == OP_REM) || (op_q == OP_REMU);
  assign is_sdiv = (op_q == OP_DIV) || (op_q == OP_REM);
  assign q_fix   = (is_sdiv && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_q : quo_q;
  assign r_fix   = (is_sdiv && a_q[XLEN-1]) ? -rem_q : rem_q;

  always_comb begin
    fix_res = is_rem ? r_fix : q_fix;
    if (bad_q)      fix_res = '0;
    else if (bz_q)  fix_res = is_rem ? a_q : '1;
    else if (ovf_q) fix_res = is_rem ? '0 : a_q;
  end

  assign res_nx = (state == S_MUL) ? mul_res : fix_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt    <= '0;
      bz_q   <= 1'b0;
      ovf_q  <= 1'b0;
      bad_q  <= 1'b0;
      Result <= '0;
      zero   <= 1'b1;
    end else begin
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        op_q  <= ALUControl;
        quo_q <= a_mag;
        dvs_q <= b_mag;
        rem_q <= '0;
        cnt   <= '0;
        bz_q  <= in_div & in_bz;
        ovf_q <= in_ovf;
        bad_q <= ~in_mul & ~in_div;
      end else if (state == S_DIV && !flush) begin
        quo_q <= quo_nx;
        rem_q <= rem_nx;
        cnt   <= cnt + 1'b1;
      end
      if ((state == S_MUL || state == S_FIX) && !flush) begin
        Result <= res_nx;
        zero   <= (res_nx == '0);
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XL-1:0] A = '0;
  logic [XL-1:0] B = '0;
  logic [3:0]    ALUControl = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [XL-1:0] Result;
  logic          zero;

  muldiv_unit #(.XLEN(XL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUControl(ALUControl), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct { logic [XL-1:0] res; int lat; } exp_t;
  exp_t          q[$];
  int            ntests = 0, nfail = 0;
  int            cyc = 0, acc_cyc = 0;
  bit            seen = 0;
  logic [XL-1:0] held_res;
  logic          held_zero;

  localparam logic [XL-1:0] MINV = {1'b1, {(XL-1){1'b0}}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit is_div(input logic [3:0] op);
    return op inside {4'b1010, 4'b1011, 4'b1100, 4'b1101};
  endfunction

  function automatic logic [XL-1:0] model(input logic [3:0] op, input logic [XL-1:0] a, input logic [XL-1:0] b);
    logic signed [2*XL-1:0] sa, sb, sbu;
    logic [2*XL-1:0]        ua, ub, p;
    logic signed [XL-1:0]   as, bs;
    bit                     ovf;
    sa  = {{XL{a[XL-1]}}, a};
    sb  = {{XL{b[XL-1]}}, b};
    sbu = {{XL{1'b0}}, b};
    ua  = {{XL{1'b0}}, a};
    ub  = {{XL{1'b0}}, b};
    as  = a;
    bs  = b;
    ovf = (a == MINV) && (b == '1);
    case (op)
      4'b1000: begin p = sa * sb;  return p[XL-1:0];    end
      4'b1001: begin p = sa * sb;  return p[2*XL-1:XL]; end
      4'b1110: begin p = sa * sbu; return p[2*XL-1:XL]; end
      4'b1111: begin p = ua * ub;  return p[2*XL-1:XL]; end
      4'b1010: return (b == 0) ? '1 : ovf ? a  : XL'(as / bs);
      4'b1011: return (b == 0) ? '1 : a / b;
      4'b1100: return (b == 0) ? a  : ovf ? '0 : XL'(as % bs);
      4'b1101: return (b == 0) ? a  : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic int lat(input logic [3:0] op, input logic [XL-1:0] a, input logic [XL-1:0] b);
    bit sgn;
    sgn = (op == 4'b1010) || (op == 4'b1100);
    if (is_div(op) && b != 0 && !(sgn && a == MINV && b == '1)) return XL + 1;
    return 1;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL unexpected_out_valid: got 1 expected 0");
      end else begin
        if (!seen) begin
          chk("latency", 64'(cyc - acc_cyc), 64'(q[0].lat));
          chk("result", Result, q[0].res);
          chk("zero", zero, q[0].res == 0);
          seen      = 1;
          held_res  = Result;
          held_zero = zero;
        end else begin
          chk("hold_result", Result, held_res);
          chk("hold_zero", zero, held_zero);
        end
        chk("in_ready_busy", in_ready, 0);
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  // Every task starts and ends just after a rising edge.
  task automatic run_op(input logic [3:0] op, input logic [XL-1:0] a, input logic [XL-1:0] b, input int hold);
    bit got;
    chk("in_ready_idle", in_ready, 1);
    A = a; B = b; ALUControl = op; in_valid = 1;
    q.push_back('{model(op, a, b), lat(op, a, b)});
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 0;
    A = $urandom; B = $urandom; ALUControl = 4'($urandom);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin got = 1; break; end
      @(posedge clk); #1;
    end
    if (!got) begin
      ntests++;
      nfail++;
      $display("FAIL timeout: out_valid got 0 expected 1 (op %b)", op);
      q.delete();
      seen = 0;
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
    end else begin
      repeat (hold) begin @(posedge clk); #1; end
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("idle_after_out", {out_valid, in_ready}, 2'b01);
    end
  endtask

  task automatic directed(input string nm, input logic [3:0] op, input logic [XL-1:0] a, input logic [XL-1:0] b,
                          input logic [XL-1:0] lit, input int hold);
    chk({"model_", nm}, model(op, a, b), lit);
    run_op(op, a, b, hold);
  endtask

  function automatic logic [XL-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return MINV;
      4: return ~MINV;
      5: return XL'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] ops [8] = '{4'b1000, 4'b1001, 4'b1110, 4'b1111, 4'b1010, 4'b1011, 4'b1100, 4'b1101};
    bit         saw;

    #12;
    chk("rst_result", Result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_out_valid", out_valid, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    directed("mulh",   4'b1001, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    directed("mulhsu", 4'b1110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    directed("mulhu",  4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    directed("mul",    4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0);
    directed("div",    4'b1010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0);
    directed("rem",    4'b1100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
    directed("divu",   4'b1011, 32'd100,      32'd7,        32'd14,       0);
    directed("remu",   4'b1101, 32'd100,      32'd7,        32'd2,        0);
    directed("div_b0", 4'b1010, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
    directed("remu_b0",4'b1101, 32'd5,        32'd0,        32'd5,        0);
    directed("div_ovf",4'b1010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    directed("rem_ovf",4'b1100, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0);
    directed("bad_op", 4'b0011, 32'd9,        32'd3,        32'd0,        0);
    directed("bp_divu",4'b1011, 32'd100,      32'd7,        32'd14,       10);
    directed("bp_mul", 4'b1000, 32'd6,        32'd7,        32'd42,       10);

    // Flush mid-divide.
    A = 32'hDEADBEEF; B = 32'd3; ALUControl = 4'b1011; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (12) begin @(posedge clk); #1; end
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_idle", {out_valid, in_ready}, 2'b01);
    saw = 0;
    repeat (40) begin @(posedge clk); #1; saw |= out_valid; end
    chk("flush_no_valid", saw, 0);
    directed("mul_after_flush", 4'b1000, 32'd3, 32'd4, 32'd12, 0);

    // Flush in IDLE blocks the accept.
    A = 32'd3; B = 32'd4; ALUControl = 4'b1000; in_valid = 1; flush = 1;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    chk("flush_idle_no_accept", {out_valid, in_ready}, 2'b01);

    // Reset mid-divide.
    A = 32'h12345678; B = 32'd5; ALUControl = 4'b1010; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (20) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    chk("rst_mid_result", Result, 0);
    chk("rst_mid_zero", zero, 1);
    chk("rst_mid_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    directed("divu_after_rst", 4'b1011, 32'd0, 32'd5, 32'd0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = (i % 10 == 9) ? 4'($urandom_range(0, 7)) : ops[$urandom_range(0, 7)];
      run_op(op, pick(), pick(), (i % 7 == 3) ? 2 : 0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
